// File: rtl/fetch_stage_pkg.sv
// Shared types for the RV32I fetch front end: instruction word, NOP, fetch FSM states
// and the {instruction, pc} entry held by the instruction buffer.
package fetch_stage_pkg;

    typedef logic [31:0] instruction_type;

    localparam instruction_type NOP_INSTRUCTION = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_type;

    typedef struct packed {
        instruction_type instr;
        logic [31:0]     pc;
    } fetch_entry_type;

    // Word-align a byte address; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: a valid/ready request channel and a
// valid-only response channel that returns words in request order.
import fetch_stage_pkg::*;

interface fetch_stage_if;
    // Request transfers on a cycle where imem_req_valid && imem_req_ready; while valid is
    // high and ready is low the address is held. A response carries no ready: the fetch
    // side always takes it, at least one cycle after its request was accepted.
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [31:0]     imem_req_addr;
    logic            imem_rsp_valid;
    instruction_type imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/fetch_buffer.sv
// Parameterised synchronous FIFO used for both the instruction buffer and the PC queue.
// Flush beats push and pop; push while full is accepted only alongside a pop.
module fetch_buffer #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count,
    output logic [WIDTH-1:0] o_head
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= bump(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= bump(r_rd_ptr);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(i_push && !i_flush && !w_do_push));
    end
endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the fetch PC, issues in-order requests under a credit limit,
// buffers returned words with their PCs and drops stale responses after a redirect.
import fetch_stage_pkg::*;

module fetch_stage #(
    parameter  logic [31:0] RESET_PC = 32'h0000_0000,
    parameter  int          DEPTH    = 2,
    localparam int          CW       = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_stage_if.master        imem,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    input  logic                 stall,
    output instruction_type      instruction,
    output logic [31:0]          pc,
    output logic                 instr_valid,
    output fetch_state_type      o_dbg_state,
    output logic [CW-1:0]        o_dbg_drop_cnt
);
    localparam int CW1 = CW + 1;

    fetch_state_type r_state;
    fetch_state_type w_next_state;
    logic [31:0]     r_req_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic            w_rsp_live;
    logic [CW-1:0]   w_remaining;
    logic            w_fetch_rsp;
    logic            w_push;
    logic            w_pop;
    logic            w_credit;
    logic            w_req_valid;
    logic            w_accept;
    logic            w_buf_full;
    logic            w_buf_empty;
    logic [CW-1:0]   w_buf_count;
    logic [63:0]     w_buf_head;
    fetch_entry_type w_head;
    logic            w_pcq_full;
    logic            w_pcq_empty;
    logic [CW-1:0]   w_pcq_count;
    logic [31:0]     w_pcq_head;

    assign w_rsp_live  = imem.imem_rsp_valid && (r_outstanding != '0);
    assign w_remaining = r_outstanding - CW'(w_rsp_live);
    assign w_fetch_rsp = (r_state == FETCH) && w_rsp_live;
    assign w_push      = w_fetch_rsp && !redirect_valid;
    assign w_pop       = !w_buf_empty && !stall;
    // A pop this cycle frees a slot before any new request can return, so it counts as credit.
    assign w_credit    = ({1'b0, r_outstanding} + {1'b0, w_buf_count}) < (CW1'(DEPTH) + CW1'(w_pop));
    assign w_accept    = w_req_valid && imem.imem_req_ready;
    assign w_head      = fetch_entry_type'(w_buf_head);

    fetch_buffer #(.WIDTH(32), .DEPTH(DEPTH)) u_pc_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_pop   (w_fetch_rsp),
        .i_flush (redirect_valid),
        .i_data  (r_req_pc),
        .o_full  (w_pcq_full),
        .o_empty (w_pcq_empty),
        .o_count (w_pcq_count),
        .o_head  (w_pcq_head)
    );

    fetch_buffer #(.WIDTH(64), .DEPTH(DEPTH)) u_instr_buffer (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  ({imem.imem_rsp_data, w_pcq_head}),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_count (w_buf_count),
        .o_head  (w_buf_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= FETCH;
            r_req_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_state <= w_next_state;
            if (redirect_valid)  r_req_pc <= align_word(redirect_pc);
            else if (w_accept)   r_req_pc <= r_req_pc + 32'd4;
            if (redirect_valid && r_state == FETCH) begin
                r_outstanding <= w_remaining;
                r_drop_cnt    <= w_remaining;
            end else begin
                r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp_live);
                if (r_state == FLUSH && w_rsp_live) r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH: if (redirect_valid && w_remaining != '0) w_next_state = FLUSH;
            FLUSH: if (r_drop_cnt == '0 || (w_rsp_live && r_drop_cnt == CW'(1))) w_next_state = FETCH;
            default: w_next_state = FETCH;
        endcase
    end

    always_comb begin
        w_req_valid    = !reset && (r_state == FETCH) && !redirect_valid && w_credit;
        o_dbg_state    = r_state;
        o_dbg_drop_cnt = r_drop_cnt;
    end

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = r_req_pc;
    assign instr_valid         = !w_buf_empty;
    assign instruction         = w_buf_empty ? NOP_INSTRUCTION : w_head.instr;
    assign pc                  = w_buf_empty ? RESET_PC : w_head.pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(imem.imem_rsp_valid && r_outstanding == '0));
            assert (!(w_fetch_rsp && w_pcq_empty));
            assert (!(w_accept && w_pcq_full));
            assert (r_state != FETCH || w_pcq_count == r_outstanding);
            assert (!(w_push && w_buf_full && !w_pop));
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized stimulus for fetch_stage against a stream-level model:
// expected request addresses, an epoch-tagged memory queue and an expected instruction queue.
import fetch_stage_pkg::*;

module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            stall;
    instruction_type instruction;
    logic [31:0]     pc;
    logic            instr_valid;
    fetch_state_type dbg_state;
    logic [1:0]      dbg_drop_cnt;

    fetch_stage_if imem();

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (imem),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instruction    (instruction),
        .pc             (pc),
        .instr_valid    (instr_valid),
        .o_dbg_state    (dbg_state),
        .o_dbg_drop_cnt (dbg_drop_cnt)
    );

    always #5 clk = ~clk;

    // Memory returns the inverted address as the instruction word.
    logic [31:0] mem_q[$];
    int          mem_ep[$];
    logic [31:0] exp_q[$];
    int          epoch;
    logic [31:0] exp_req_pc;
    int          n_vec;
    int          n_err;
    int          ready_pct;
    int          rsp_pct;
    logic        last_rv;
    logic [31:0] last_addr;

    function automatic int stale_count();
        int n = 0;
        foreach (mem_ep[i]) if (mem_ep[i] != epoch) n++;
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_vec++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    task automatic tick();
        logic rv, rdy, rsp, redir, popped;
        logic [31:0] ra, a;
        int e;
        rdy = ($urandom_range(99) < ready_pct);
        rsp = !reset && (mem_q.size() != 0) && ($urandom_range(99) < rsp_pct);
        imem.imem_req_ready = rdy;
        imem.imem_rsp_valid = rsp;
        imem.imem_rsp_data  = rsp ? ~mem_q[0] : 32'h0;
        @(negedge clk);
        rv     = imem.imem_req_valid;
        ra     = imem.imem_req_addr;
        redir  = redirect_valid;
        popped = (exp_q.size() != 0) && !stall;
        if (reset) begin
            check("req_valid_in_reset", 32'(rv), 32'd0);
        end else begin
            check("req_valid", 32'(rv),
                  32'(!redir && stale_count() == 0 && (mem_q.size() + exp_q.size() < DEPTH + int'(popped))));
            if (rv) check("req_addr", ra, exp_req_pc);
        end
        last_rv   = rv;
        last_addr = ra;
        @(posedge clk);
        #1;
        if (reset) begin
            mem_q.delete();
            mem_ep.delete();
            exp_q.delete();
            exp_req_pc = RESET_PC;
            epoch++;
        end else begin
            if (popped && !redir) void'(exp_q.pop_front());
            if (rsp) begin
                a = mem_q.pop_front();
                e = mem_ep.pop_front();
                if (!redir && e == epoch) exp_q.push_back(a);
            end
            if (rv && rdy) begin
                mem_q.push_back(ra);
                mem_ep.push_back(epoch);
                exp_req_pc = exp_req_pc + 32'd4;
            end
            if (redir) begin
                exp_q.delete();
                epoch++;
                exp_req_pc = redirect_pc & 32'hFFFF_FFFC;
            end
        end
        check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("pc", pc, exp_q[0]);
            check("instruction", instruction, ~exp_q[0]);
        end else begin
            check("nop_when_idle", instruction, NOP_INSTRUCTION);
        end
        check("state_flush", 32'(dbg_state == FLUSH), 32'(stale_count() != 0));
        check("drop_cnt", 32'(dbg_drop_cnt), 32'(stale_count()));
    endtask

    task automatic restart();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem.imem_req_ready = 1'b0; imem.imem_rsp_valid = 1'b0; imem.imem_rsp_data = 32'h0;
        mem_q.delete(); mem_ep.delete(); exp_q.delete();
        epoch = 0; exp_req_pc = RESET_PC; n_vec = 0; n_err = 0;
        ready_pct = 100; rsp_pct = 100; last_rv = 1'b0; last_addr = 32'h0;

        // Reset values and zero-wait streaming
        tick(); tick();
        check("rst_pc", pc, RESET_PC);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instruction, NOP_INSTRUCTION);
        check("rst_state", 32'(dbg_state), 32'(FETCH));
        reset = 1'b0;
        tick();
        check("t1_first_req", 32'(last_rv), 32'd1);
        check("t1_first_addr", last_addr, RESET_PC);
        check("t1_lat_n1", 32'(instr_valid), 32'd0);
        tick();
        check("t1_lat_n2", 32'(instr_valid), 32'd1);
        check("t1_pc0", pc, 32'h0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("t1_valid_seq", 32'(instr_valid), 32'd1);
            check("t1_pc_seq", pc, 32'(4 * i));
        end

        // Stall for 6 cycles: requests stop once DEPTH words are in flight or buffered
        stall = 1'b1;
        repeat (6) tick();
        check("t2_req_dropped", 32'(last_rv), 32'd0);
        check("t2_held", 32'(instr_valid), 32'd1);
        stall = 1'b0;
        repeat (8) tick();

        // Memory not ready for 3 cycles at address 0x8
        restart();
        tick(); tick();
        ready_pct = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_valid_held", 32'(last_rv), 32'd1);
            check("t3_addr_held", last_addr, 32'h8);
        end
        ready_pct = 100;
        tick(); tick();
        check("t3_pc8", pc, 32'h8);
        check("t3_pc8_valid", 32'(instr_valid), 32'd1);

        // Redirect to 0x103 with two requests outstanding
        restart();
        rsp_pct = 0;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        check("t4_flush", 32'(dbg_state), 32'(FLUSH));
        check("t4_drop2", 32'(dbg_drop_cnt), 32'd2);
        rsp_pct = 100;
        tick();
        check("t4_drop1", 32'(dbg_drop_cnt), 32'd1);
        tick();
        check("t4_back_fetch", 32'(dbg_state), 32'(FETCH));
        for (int k = 0; k < 10 && !instr_valid; k++) tick();
        check("t4_first_valid", 32'(instr_valid), 32'd1);
        check("t4_first_pc", pc, 32'h100);

        // Redirect together with a response and a pop, one outstanding
        restart();
        tick(); tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("t5_valid_off", 32'(instr_valid), 32'd0);
        check("t5_drop0", 32'(dbg_drop_cnt), 32'd0);
        check("t5_state", 32'(dbg_state), 32'(FETCH));
        tick();
        check("t5_req", 32'(last_rv), 32'd1);
        check("t5_req_addr", last_addr, 32'h200);

        // Reset while flushing
        restart();
        rsp_pct = 0;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        check("t6_in_flush", 32'(dbg_state), 32'(FLUSH));
        reset = 1'b1;
        tick();
        check("t6_rst_pc", pc, RESET_PC);
        check("t6_rst_valid", 32'(instr_valid), 32'd0);
        check("t6_rst_state", 32'(dbg_state), 32'(FETCH));
        reset = 1'b0;
        rsp_pct = 100;
        tick();
        check("t6_req", 32'(last_rv), 32'd1);
        check("t6_req_addr", last_addr, RESET_PC);

        // PC wrap across 2^32
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFA;
        tick();
        redirect_valid = 1'b0;
        repeat (8) tick();

        // Randomized traffic with stalls, wait states and redirects
        for (int seg = 0; seg < 8; seg++) begin
            ready_pct = $urandom_range(100, 30);
            rsp_pct   = $urandom_range(100, 30);
            for (int c = 0; c < 50; c++) begin
                stall          = ($urandom_range(99) < 25);
                redirect_valid = ($urandom_range(99) < 4);
                redirect_pc    = $urandom;
                tick();
            end
        end
        stall = 1'b0; redirect_valid = 1'b0; ready_pct = 100; rsp_pct = 100;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
